// File: rtl/baud_gen.sv
// baud_gen: free-running tick generator, one pulse every round(clk_hz/baud) clocks
module baud_gen #(
    parameter int clk_hz = 12000000,
    parameter int baud   = 115200
) (
    input  logic clk,
    input  logic reset,
    output logic baud_tick
);
    localparam int DIV = (clk_hz + baud / 2) / baud;
    localparam int CW  = (DIV <= 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("baud_gen: divisor (clk_hz+baud/2)/baud=%0d is below 2 for clk_hz=%0d baud=%0d", DIV, clk_hz, baud);
    end

    logic [CW-1:0] cnt    = '0;
    logic          tick_q = 1'b0;
    logic          last;

    assign last      = cnt == CW'(DIV - 1);
    assign baud_tick = tick_q;

    // count 0..DIV-1 and raise the registered tick on the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= last ? '0 : cnt + 1'b1;
            tick_q <= last;
        end
    end
endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen: directed checks of tick positions for three divisors
module tb_baud_gen;
    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic tick_a, tick_b, tick_c;
    int checks = 0;
    int errors = 0;
    int c_ticks = 0;
    int c_last = 0;

    always #5 clk = ~clk;

    baud_gen #(.clk_hz(100), .baud(10)) dut_a (.clk(clk), .reset(reset_a), .baud_tick(tick_a));
    baud_gen #(.clk_hz(100), .baud(30)) dut_b (.clk(clk), .reset(1'b0), .baud_tick(tick_b));
    baud_gen #(.clk_hz(12000000), .baud(115200)) dut_c (.clk(clk), .reset(1'b0), .baud_tick(tick_c));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected DIV=10 tick: free run, reset on edges 51-53, reset on edge 80
    function automatic bit exp_a(input int k);
        if (k <= 50) return k % 10 == 0;
        if (k <= 53) return 1'b0;
        if (k <= 80) return k != 80 && (k - 53) % 10 == 0;
        return (k - 80) % 10 == 0;
    endfunction

    initial begin
        #1;
        check("powerup_a", int'(tick_a), 0);
        check("powerup_b", int'(tick_b), 0);
        check("powerup_c", int'(tick_c), 0);
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk);
            #1;
            if (k <= 150) check($sformatf("a_edge%0d", k), int'(tick_a), int'(exp_a(k)));
            if (k <= 30) check($sformatf("b_edge%0d", k), int'(tick_b), int'(k % 3 == 0));
            check($sformatf("c_edge%0d", k), int'(tick_c), int'(k % 104 == 0));
            if (tick_c) begin
                if (c_ticks > 0) check($sformatf("c_spacing%0d", k), k - c_last, 104);
                c_ticks++;
                c_last = k;
            end
            reset_a = (k >= 50 && k <= 52) || k == 79;
        end
        check("c_tick_count", c_ticks, 9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
